// File: rtl/serial_in.sv
// serial_in: receive side of the dual-frequency serial link; LSB-first, mid-window sampling.
// Define SERIAL_IN_GLITCH_CHECK_EN for 3-sample majority voting with a sticky o_err flag.
module serial_in #(
  parameter int DATA_BIT    = 32,
  parameter int LOW_FREQ    = 9,
  parameter int HIGH_FREQ   = 3,
  parameter int SYNC_STAGES = 2,
  parameter int ALIGN_DLY   = 3,
  parameter int FRAME_GAP   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_mode,
  input  logic [DATA_BIT-1:0] i_freq_pattern,
  input  logic                i_serial_in,
  output logic [DATA_BIT-1:0] o_data,
  output logic                o_valid,
  output logic                o_bit_tick,
  output logic                o_busy,
  output logic                o_err
);

  localparam int IDX_W = $clog2(DATA_BIT) + 1;
  localparam logic [7:0] LOW_P     = 8'(LOW_FREQ);
  localparam logic [7:0] HIGH_P    = 8'(HIGH_FREQ);
  localparam logic [7:0] ALIGN_CNT = 8'(ALIGN_DLY - 1);
  localparam logic [7:0] GAP_CNT   = 8'(FRAME_GAP - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_RECV, S_DONE} state_t;

  state_t              state, state_d;
  logic [SYNC_STAGES-1:0] sync;
  logic                line;
  logic                mode_r;
  logic [DATA_BIT-1:0] freq_buf, shift_buf;
  logic [7:0]          count, count_d;
  logic [IDX_W-1:0]    idx, idx_d;
  logic                load, sample_en, valid_d, bit_val;
  logic [7:0]          cur_p, nxt_p, p0_buf, p0_new, off, half, take_off;

  assign line   = sync[SYNC_STAGES-1];
  assign cur_p  = freq_buf[idx[IDX_W-2:0]] ? HIGH_P : LOW_P;
  assign nxt_p  = freq_buf[idx[IDX_W-2:0] + (IDX_W-1)'(1)] ? HIGH_P : LOW_P;
  assign p0_buf = freq_buf[0] ? HIGH_P : LOW_P;
  assign p0_new = i_freq_pattern[0] ? HIGH_P : LOW_P;
  // count runs P-1..0, so the position inside the bit window is P-1-count
  assign off    = cur_p - 8'd1 - count;
  assign half   = cur_p >> 1;

`ifdef SERIAL_IN_GLITCH_CHECK_EN
  logic [7:0] off_lo, off_hi;
  logic       s0_r, s1_r, err_flag, v_lo, v_mid, glitch;

  assign off_lo   = half - 8'd1;
  assign off_hi   = (half + 8'd1 > cur_p - 8'd1) ? cur_p - 8'd1 : half + 8'd1;
  assign take_off = off_hi;
  // Vote is resolved at the latest offset; clamped offsets collapse onto the live sample
  assign v_lo     = (off_lo == off_hi) ? line : s0_r;
  assign v_mid    = (half == off_hi) ? line : s1_r;
  assign bit_val  = (v_lo & v_mid) | (v_lo & line) | (v_mid & line);
  assign glitch   = (v_lo != v_mid) || (v_mid != line);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_r     <= 1'b0;
      s1_r     <= 1'b0;
      err_flag <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      if (state == S_RECV && off == off_lo) s0_r <= line;
      if (state == S_RECV && off == half)   s1_r <= line;
      if (load)                       err_flag <= 1'b0;
      else if (sample_en && glitch)   err_flag <= 1'b1;
      if (valid_d) o_err <= err_flag;
    end
  end
`else
  assign take_off = half;
  assign bit_val  = line;
  assign o_err    = 1'b0;
`endif

  always_comb begin
    state_d   = state;
    count_d   = count;
    idx_d     = idx;
    load      = 1'b0;
    sample_en = 1'b0;
    valid_d   = 1'b0;
    if (i_stop) begin
      state_d = S_IDLE;
    end else if (i_start) begin
      load  = 1'b1;
      idx_d = '0;
      if (ALIGN_DLY == 0) begin
        state_d = S_RECV;
        count_d = p0_new - 8'd1;
      end else begin
        state_d = S_ALIGN;
        count_d = ALIGN_CNT;
      end
    end else begin
      case (state)
        S_ALIGN: begin
          if (count == '0) begin
            state_d = S_RECV;
            idx_d   = '0;
            count_d = p0_buf - 8'd1;
          end else begin
            count_d = count - 8'd1;
          end
        end
        S_RECV: begin
          sample_en = (off == take_off);
          if (count == '0) begin
            if (idx == LAST_IDX) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx + IDX_W'(1);
              count_d = nxt_p - 8'd1;
            end
          end else begin
            count_d = count - 8'd1;
          end
        end
        S_DONE: begin
          valid_d = 1'b1;
          idx_d   = '0;
          if (!mode_r) begin
            state_d = S_IDLE;
          end else if (FRAME_GAP == 0) begin
            state_d = S_RECV;
            count_d = p0_buf - 8'd1;
          end else begin
            state_d = S_ALIGN;
            count_d = GAP_CNT;
          end
        end
        default: state_d = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      sync       <= '0;
      mode_r     <= 1'b0;
      freq_buf   <= '0;
      shift_buf  <= '0;
      count      <= '0;
      idx        <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_bit_tick <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      sync       <= (sync << 1) | SYNC_STAGES'(i_serial_in);
      state      <= state_d;
      count      <= count_d;
      idx        <= idx_d;
      o_busy     <= (state_d != S_IDLE);
      o_valid    <= valid_d;
      o_bit_tick <= sample_en;
      if (load) begin
        mode_r    <= i_mode;
        freq_buf  <= i_freq_pattern;
        shift_buf <= '0;
      end else if (sample_en) begin
        shift_buf[idx[IDX_W-2:0]] <= bit_val;
      end
      if (valid_d) o_data <= shift_buf;
    end
  end

endmodule

// File: tb/tb_serial_in.sv
// tb_serial_in: line waveform computed from the frame timing rules; scoreboard checks each o_valid.
`timescale 1ns/1ps
module tb_serial_in;
  localparam int DW = 32, LOW = 9, HIGH = 3, SYNC = 2, ALIGN = 3, GAP = 1;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          i_start = 1'b0, i_stop = 1'b0, i_mode = 1'b0, i_serial_in = 1'b0;
  logic [DW-1:0] i_freq_pattern = '0;
  logic [DW-1:0] o_data;
  logic          o_valid, o_bit_tick, o_busy, o_err;

  serial_in #(.DATA_BIT(DW), .LOW_FREQ(LOW), .HIGH_FREQ(HIGH), .SYNC_STAGES(SYNC),
              .ALIGN_DLY(ALIGN), .FRAME_GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_stop(i_stop), .i_mode(i_mode),
    .i_freq_pattern(i_freq_pattern), .i_serial_in(i_serial_in), .o_data(o_data),
    .o_valid(o_valid), .o_bit_tick(o_bit_tick), .o_busy(o_busy), .o_err(o_err));

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] data; logic err; } exp_t;
  exp_t          sb[$];
  exp_t          mon_e;
  logic [DW-1:0] fdata[$];
  logic [DW-1:0] fr_freq = '0;
  logic [DW-1:0] last_word = '0;
  int checks = 0, failures = 0, ticks = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic int per(logic [DW-1:0] fq, int k);
    return fq[k] ? HIGH : LOW;
  endfunction

  function automatic int frame_len(logic [DW-1:0] fq);
    int s = 0;
    for (int k = 0; k < DW; k++) s += per(fq, k);
    return s;
  endfunction

  // cycle (counted from the cycle after the start edge) at which bit k's window opens
  function automatic int bstart(logic [DW-1:0] fq, int k);
    int s = ALIGN;
    for (int i = 0; i < k; i++) s += per(fq, i);
    return s;
  endfunction

  // value the receiver should see inside its sampling window at cycle w
  function automatic logic line_at(int w);
    int t, p;
    t = w - ALIGN;
    if (t < 0) return 1'b0;
    for (int f = 0; f < fdata.size(); f++) begin
      for (int k = 0; k < DW; k++) begin
        p = per(fr_freq, k);
        if (t < p) return fdata[f][k];
        t -= p;
      end
      t -= 1 + GAP;
      if (t < 0) return 1'b0;
    end
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (o_bit_tick) ticks++;
      if (o_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid: got o_data=%0h expected no o_valid", o_data);
        end else begin
          mon_e = sb.pop_front();
          check("o_data", o_data, mon_e.data);
          check("o_err", o_err, mon_e.err);
          last_word = mon_e.data;
        end
      end
    end
  end

  task automatic launch(input bit mode, input logic [DW-1:0] fq, input int ncyc,
                        input int stop_at, input int rst_at, input int glitch_w);
    bit chk_busy;
    chk_busy = (stop_at < 0 || stop_at >= 1) && (rst_at < 0 || rst_at > 1);
    @(negedge clk);
    i_start = 1'b1; i_stop = 1'b0; i_mode = mode; i_freq_pattern = fq; i_serial_in = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      i_start        = 1'b0;
      i_mode         = 1'($urandom);
      i_freq_pattern = $urandom;
      i_serial_in    = line_at(c + SYNC) ^ logic'(c + SYNC == glitch_w);
      i_stop         = (c == stop_at);
      if (c == 1 && chk_busy) check("busy_in_frame", o_busy, 1);
      if (stop_at >= 0 && c == stop_at + 1) check("busy_after_stop", o_busy, 0);
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_o_data", o_data, 0);
        check("rst_o_valid", o_valid, 0);
        check("rst_o_bit_tick", o_bit_tick, 0);
        check("rst_o_busy", o_busy, 0);
        check("rst_o_err", o_err, 0);
        last_word = '0;
      end
    end
    i_serial_in = 1'b0;
    i_stop      = 1'b0;
  endtask

  task automatic full_run(input bit mode, input logic [DW-1:0] fq, input int glitch_w,
                          input logic err_exp);
    int   t0, d_last;
    exp_t e;
    fr_freq = fq;
    foreach (fdata[f]) begin
      e.data = fdata[f];
      e.err  = err_exp;
      sb.push_back(e);
    end
    d_last = ALIGN + (fdata.size() - 1) * (frame_len(fq) + 1 + GAP) + frame_len(fq);
    t0 = ticks;
    launch(mode, fq, d_last + 4, mode ? d_last + 1 : -1, -1, glitch_w);
    check("busy_after_frame", o_busy, 0);
    check("bit_ticks", ticks - t0, DW * fdata.size());
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    int            t0;
    bit            m;
    logic [DW-1:0] fq;
    repeat (3) @(negedge clk);
    check("reset_o_data", o_data, 0);
    check("reset_o_valid", o_valid, 0);
    check("reset_o_bit_tick", o_bit_tick, 0);
    check("reset_o_busy", o_busy, 0);
    check("reset_o_err", o_err, 0);
    rst_n = 1'b1;

    fdata = '{32'hA5A5_1234};
    full_run(0, 32'h0000_0000, -1, 1'b0);
    check("held_data", o_data, 32'hA5A5_1234);

    fdata = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    full_run(1, 32'hF0F0_F0F0, -1, 1'b0);

    // abort at the opening of bit 10
    fq = $urandom; fr_freq = fq; fdata = '{32'h0}; fdata[0] = $urandom; t0 = ticks;
    launch(0, fq, bstart(fq, 10) + 4, bstart(fq, 10), -1, -1);
    check("stop_ticks", ticks - t0, 10);
    check("stop_keeps_data", o_data, last_word);
    check("stop_busy", o_busy, 0);

    // re-arm during bit 20; only the second word may appear
    fq = $urandom; fr_freq = fq; fdata[0] = $urandom; t0 = ticks;
    launch(0, fq, bstart(fq, 20) + 1, -1, -1, -1);
    check("partial_ticks", ticks - t0, 20);
    fdata = '{32'h0000_0001};
    full_run(0, $urandom, -1, 1'b0);

    fq = $urandom; fr_freq = fq; fdata[0] = $urandom;
    launch(0, fq, bstart(fq, 12) + 40, -1, bstart(fq, 12), -1);
    check("after_reset_busy", o_busy, 0);
    check("after_reset_data", o_data, last_word);

    @(negedge clk); i_start = 1'b1; i_stop = 1'b1; i_freq_pattern = $urandom;
    @(negedge clk); i_start = 1'b0; i_stop = 1'b0;
    check("start_stop_idle", o_busy, 0);

    for (int r = 0; r < 5; r++) begin
      m  = 1'($urandom);
      fq = $urandom;
      fdata = {};
      repeat (m ? 2 : 1) fdata.push_back($urandom);
      full_run(m, fq, -1, 1'b0);
    end

`ifdef SERIAL_IN_GLITCH_CHECK_EN
    fdata = '{32'h0}; fdata[0] = $urandom;
    full_run(0, 32'h0000_0000, ALIGN + 5 * LOW + LOW / 2, 1'b1);
    fdata[0] = $urandom;
    full_run(0, 32'h0000_0000, -1, 1'b0);
`endif

    repeat (5) @(negedge clk);
    check("sb_final", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
